// File: rtl/cra_pkg.sv
// cra_pkg: shared next-address op codes, diagnostic selects and flag bit positions.
// Revision 1.0
`default_nettype none

package cra_pkg;

   typedef enum logic [2:0] {
      OP_JUMP     = 3'd0,
      OP_SKIP     = 3'd1,
      OP_DISP     = 3'd2,
      OP_CALL     = 3'd3,
      OP_RET      = 3'd4,
      OP_CALLDISP = 3'd5
   } cra_op_e;

   typedef enum logic [1:0] {
      DIAG_ADR   = 2'd0,
      DIAG_TOP   = 2'd1,
      DIAG_SP    = 2'd2,
      DIAG_FLAGS = 2'd3
   } cra_diag_e;

   // Bit positions within the flags readback word, counted up from the LSB.
   localparam int FLAG_OVF_BIT = 0;
   localparam int FLAG_UNF_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/cra_ustack.sv
// cra_ustack: microcode call/return stack with saturating push and sticky ovf/unf flags.
// Revision 1.0
`default_nettype none

module cra_ustack #(
   parameter int ADR_W       = 11,
   parameter int STACK_DEPTH = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic                           push_i,
   input  logic                           pop_i,
   input  logic [ADR_W-1:0]               wdata_i,
   output logic [ADR_W-1:0]               top_o,
   output logic [$clog2(STACK_DEPTH):0]   sp_o,
   output logic                           ovf_o,
   output logic                           unf_o
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam logic [IDX_W:0] SP_FULL = (IDX_W+1)'(STACK_DEPTH);

   logic [ADR_W-1:0] mem_q [STACK_DEPTH];
   logic [IDX_W:0]   sp_q, sp_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             full, empty;
   logic [IDX_W-1:0] top_idx, wr_idx;

   assign full    = (sp_q == SP_FULL);
   assign empty   = (sp_q == '0);
   // Low bits wrap to STACK_DEPTH-1 when the stack is full.
   assign top_idx = sp_q[IDX_W-1:0] - IDX_W'(1);
   assign wr_idx  = full ? top_idx : sp_q[IDX_W-1:0];

   always_comb begin
      sp_d  = sp_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (push_i) begin
         if (full) ovf_d = 1'b1;
         else      sp_d  = sp_q + (IDX_W+1)'(1);
      end else if (pop_i) begin
         if (empty) unf_d = 1'b1;
         else       sp_d  = sp_q - (IDX_W+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_n_i && push_i) mem_q[wr_idx] <= wdata_i;
   end

   assign top_o = empty ? '0 : mem_q[top_idx];
   assign sp_o  = sp_q;
   assign ovf_o = ovf_q;
   assign unf_o = unf_q;

endmodule

`default_nettype wire

// File: rtl/cra_useq.sv
// cra_useq: CRAM next-address sequencer (jump/skip/dispatch/call/return/trap) with EBUS readback.
// Revision 1.0 -- optional address parity via CRA_USEQ_PARITY_EN.
`default_nettype none

module cra_useq
   import cra_pkg::*;
#(
   parameter int ADR_W       = 11,
   parameter int STACK_DEPTH = 16,
   parameter int NDISP       = 4,
   parameter int SKIP_N      = 16
) (
   input  logic                       clk_cra_h,
   input  logic                       mr_reset_l,
   input  logic                       stall_h,
   input  logic [ADR_W-1:0]           cram_j_h,
   input  logic [2:0]                 cram_op_h,
   input  logic [$clog2(SKIP_N)-1:0]  cram_skip_sel_h,
   input  logic [SKIP_N-1:0]          skip_cond_h,
   input  logic [$clog2(NDISP)-1:0]   cram_disp_sel_h,
   input  logic [NDISP*ADR_W-1:0]     disp_vec_h,
   input  logic                       force_trap_h,
`ifdef CRA_USEQ_PARITY_EN
   input  logic                       cram_par_err_h,
   output logic                       cra_adr_par_h,
`endif
   input  logic                       diag_rd_h,
   input  logic [1:0]                 diag_sel_h,
   output logic [ADR_W-1:0]           cra_adr_h,
   output logic [ADR_W-1:0]           ebus_data_h,
   output logic                       stack_ovf_h,
   output logic                       stack_unf_h
);

   localparam int SP_W = $clog2(STACK_DEPTH) + 1;

   logic [ADR_W-1:0] adr_q, adr_d;
   logic [ADR_W-1:0] ebus_q, ebus_d;
   logic [ADR_W-1:0] diag_val, disp_val, stk_top;
   logic [SP_W-1:0]  stk_sp;
   logic             stk_ovf, stk_unf;
   logic             push, pop, trap, skip_bit;

`ifdef CRA_USEQ_PARITY_EN
   assign trap = force_trap_h | cram_par_err_h;
`else
   assign trap = force_trap_h;
`endif

   // Selects beyond SKIP_N / NDISP match no channel and read as zero.
   always_comb begin
      skip_bit = 1'b0;
      for (int k = 0; k < SKIP_N; k++)
         if (32'(cram_skip_sel_h) == k) skip_bit = skip_cond_h[k];
   end

   always_comb begin
      disp_val = '0;
      for (int k = 0; k < NDISP; k++)
         if (32'(cram_disp_sel_h) == k) disp_val = disp_vec_h[k*ADR_W +: ADR_W];
   end

   always_comb begin
      adr_d = cram_j_h;
      push  = 1'b0;
      pop   = 1'b0;
      if (trap) begin
         push  = 1'b1;
         adr_d = '1;
      end else begin
         case (cram_op_h)
            OP_SKIP:     adr_d = {cram_j_h[ADR_W-1:1], cram_j_h[0] | skip_bit};
            OP_DISP:     adr_d = cram_j_h | disp_val;
            OP_CALL:     push  = 1'b1;
            OP_RET: begin
               pop   = 1'b1;
               adr_d = cram_j_h | stk_top;
            end
            OP_CALLDISP: begin
               push  = 1'b1;
               adr_d = cram_j_h | disp_val;
            end
            default:     adr_d = cram_j_h;
         endcase
      end
   end

   always_comb begin
      diag_val = '0;
      case (diag_sel_h)
         DIAG_ADR:   diag_val = adr_q;
         DIAG_TOP:   diag_val = stk_top;
         DIAG_SP:    diag_val = ADR_W'(stk_sp);
         DIAG_FLAGS: begin
            diag_val[FLAG_OVF_BIT] = stk_ovf;
            diag_val[FLAG_UNF_BIT] = stk_unf;
         end
         default:    diag_val = '0;
      endcase
      ebus_d = diag_rd_h ? diag_val : '0;
   end

   cra_ustack #(
      .ADR_W       (ADR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ustack (
      .clk_i   (clk_cra_h),
      .rst_n_i (mr_reset_l),
      .push_i  (push & ~stall_h),
      .pop_i   (pop & ~stall_h),
      .wdata_i (adr_q),
      .top_o   (stk_top),
      .sp_o    (stk_sp),
      .ovf_o   (stk_ovf),
      .unf_o   (stk_unf)
   );

   always_ff @(posedge clk_cra_h) begin
      if (!mr_reset_l) begin
         adr_q  <= '0;
         ebus_q <= '0;
      end else if (!stall_h) begin
         adr_q  <= adr_d;
         ebus_q <= ebus_d;
      end
   end

`ifdef CRA_USEQ_PARITY_EN
   logic par_q;

   always_ff @(posedge clk_cra_h) begin
      if (!mr_reset_l)  par_q <= 1'b1;
      else if (!stall_h) par_q <= ~^adr_d;
   end

   assign cra_adr_par_h = par_q;
`endif

   assign cra_adr_h   = adr_q;
   assign ebus_data_h = ebus_q;
   assign stack_ovf_h = stk_ovf;
   assign stack_unf_h = stk_unf;

endmodule

`default_nettype wire

// File: tb/tb_cra_useq.sv
// tb_cra_useq: table vectors, directed stack/trap sequences and random stimulus against a queue-based model.
// Revision 1.0
`default_nettype none

module tb_cra_useq;
   import cra_pkg::*;

   logic        clk = 1'b0;
   logic        rst_l, stall, trap, drd;
   logic [10:0] j;
   logic [2:0]  op;
   logic [3:0]  ssel;
   logic [15:0] scond;
   logic [1:0]  dsel, diag_sel;
   logic [43:0] dvec;
   logic [10:0] adr, ebus;
   logic        ovf, unf;
   logic        par_err;
`ifdef CRA_USEQ_PARITY_EN
   logic        par;
`endif

   always #5 clk = ~clk;

   cra_useq dut (
      .clk_cra_h       (clk),
      .mr_reset_l      (rst_l),
      .stall_h         (stall),
      .cram_j_h        (j),
      .cram_op_h       (op),
      .cram_skip_sel_h (ssel),
      .skip_cond_h     (scond),
      .cram_disp_sel_h (dsel),
      .disp_vec_h      (dvec),
      .force_trap_h    (trap),
`ifdef CRA_USEQ_PARITY_EN
      .cram_par_err_h  (par_err),
      .cra_adr_par_h   (par),
`endif
      .diag_rd_h       (drd),
      .diag_sel_h      (diag_sel),
      .cra_adr_h       (adr),
      .ebus_data_h     (ebus),
      .stack_ovf_h     (ovf),
      .stack_unf_h     (unf)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: address, diag register, flags and a queue as the stack.
   logic [10:0] m_adr, m_ebus;
   logic [10:0] m_stk[$];
   bit          m_ovf, m_unf;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0o expected %0o", name, act, exp);
      end
   endtask

   task automatic m_push(input logic [10:0] v);
      if (m_stk.size() == 16) begin
         m_stk[15] = v;
         m_ovf = 1'b1;
      end else
         m_stk.push_back(v);
   endtask

   task automatic model_edge();
      logic [10:0] nadr, dv, top, rd;
      bit          sk;
      if (!rst_l) begin
         m_adr = 0; m_ebus = 0; m_ovf = 0; m_unf = 0;
         m_stk.delete();
      end else if (!stall) begin
         top = (m_stk.size() == 0) ? 11'd0 : m_stk[$];
         case (diag_sel)
            2'd0:    rd = m_adr;
            2'd1:    rd = top;
            2'd2:    rd = 11'(m_stk.size());
            default: rd = {9'd0, m_unf, m_ovf};
         endcase
         sk = scond[ssel];
         dv = 11'(dvec >> (int'(dsel) * 11));
         nadr = j;
         if (trap || par_err) begin
            m_push(m_adr);
            nadr = 11'h7FF;
         end else begin
            case (op)
               3'd1: nadr = j | {10'd0, sk};
               3'd2: nadr = j | dv;
               3'd3: m_push(m_adr);
               3'd4: begin
                  if (m_stk.size() == 0) m_unf = 1'b1;
                  else void'(m_stk.pop_back());
                  nadr = j | top;
               end
               3'd5: begin
                  m_push(m_adr);
                  nadr = j | dv;
               end
               default: nadr = j;
            endcase
         end
         m_adr  = nadr;
         m_ebus = drd ? rd : 11'd0;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("adr", adr, m_adr);
      chk("ebus", ebus, m_ebus);
      chk("ovf", ovf, m_ovf);
      chk("unf", unf, m_unf);
`ifdef CRA_USEQ_PARITY_EN
      chk("parity", par, ~^m_adr);
`endif
   endtask

   task automatic idle();
      rst_l = 1; stall = 0; trap = 0; par_err = 0; drd = 0; diag_sel = 0;
      op = 3'd0; j = 0; ssel = 0; scond = 0; dsel = 0; dvec = 0;
   endtask

   typedef struct {
      bit        stall;
      bit [2:0]  op;
      bit [10:0] j;
      bit [3:0]  ssel;
      bit [15:0] scond;
      bit [1:0]  dsel;
      bit [10:0] vec;
      bit [10:0] exp;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b0, 3'd0, 11'o0123, 4'd0, 16'h0000, 2'd0, 11'o0000, 11'o0123};
      tbl[1] = '{1'b0, 3'd1, 11'o0200, 4'd5, 16'h0020, 2'd0, 11'o0000, 11'o0201};
      tbl[2] = '{1'b0, 3'd1, 11'o0200, 4'd5, 16'hFFDF, 2'd0, 11'o0000, 11'o0200};
      tbl[3] = '{1'b0, 3'd2, 11'o0400, 4'd0, 16'h0000, 2'd2, 11'o0017, 11'o0417};
      tbl[4] = '{1'b1, 3'd2, 11'o0600, 4'd0, 16'h0000, 2'd2, 11'o0017, 11'o0417};
      tbl[5] = '{1'b0, 3'd0, 11'o0050, 4'd0, 16'h0000, 2'd0, 11'o0000, 11'o0050};
      tbl[6] = '{1'b0, 3'd3, 11'o0300, 4'd0, 16'h0000, 2'd0, 11'o0000, 11'o0300};
      tbl[7] = '{1'b0, 3'd4, 11'o0002, 4'd0, 16'h0000, 2'd0, 11'o0000, 11'o0052};

      idle();
      #1;
      rst_l = 0; drd = 1;
      step();
      step();
      chk("rst_adr", adr, 0);
      chk("rst_ebus", ebus, 0);
      idle();

      for (int i = 0; i < 8; i++) begin
         stall = tbl[i].stall; op = tbl[i].op; j = tbl[i].j;
         ssel = tbl[i].ssel; scond = tbl[i].scond; dsel = tbl[i].dsel;
         dvec = {12'($urandom()), $urandom()};
         dvec[int'(tbl[i].dsel) * 11 +: 11] = tbl[i].vec;
         step();
         chk("tbl_adr", adr, tbl[i].exp);
      end
      idle();
      j = 11'o0052; drd = 1; diag_sel = 2'd2;
      step();
      chk("sp_after_ret", ebus, 0);

      // Overflow: 17 calls into a 16-deep stack.
      idle();
      for (int i = 0; i < 17; i++) begin
         op = 3'd3; j = 11'(11'o0100 + i);
         step();
      end
      chk("ovf_set", ovf, 1);
      idle();
      j = 11'o0116; drd = 1; diag_sel = 2'd2;
      step();
      chk("sp_full", ebus, 16);

      // Drain, then underflow on the empty stack.
      idle();
      for (int i = 0; i < 16; i++) begin
         op = 3'd4; j = 0;
         step();
      end
      op = 3'd4; j = 11'o0007;
      step();
      chk("unf_adr", adr, 11'o0007);
      chk("unf_set", unf, 1);
      chk("ovf_sticky", ovf, 1);
      idle();
      op = 3'd0; j = 11'o0001;
      step();
      chk("unf_sticky", unf, 1);
      rst_l = 0;
      step();
      chk("ovf_clr", ovf, 0);
      chk("unf_clr", unf, 0);

      // Trap while a CALL is presented.
      idle();
      j = 11'o0100;
      step();
      op = 3'd3; j = 11'o0555; trap = 1;
      step();
      chk("trap_adr", adr, 11'o3777);
      idle();
      j = 11'o3777; drd = 1; diag_sel = 2'd2;
      step();
      chk("trap_sp", ebus, 1);
      diag_sel = 2'd1;
      step();
      chk("trap_top", ebus, 11'o0100);

      // Random stimulus against the model.
      for (int n = 0; n < 600; n++) begin
         rst_l    = ($urandom_range(63) != 0);
         stall    = ($urandom_range(7) == 0);
         trap     = ($urandom_range(15) == 0);
`ifdef CRA_USEQ_PARITY_EN
         par_err  = ($urandom_range(31) == 0);
`endif
         op       = 3'($urandom_range(7));
         j        = 11'($urandom());
         ssel     = 4'($urandom());
         scond    = 16'($urandom());
         dsel     = 2'($urandom());
         dvec     = {12'($urandom()), $urandom()};
         drd      = 1'($urandom());
         diag_sel = 2'($urandom());
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
